// File: rtl/reaction_seq_ctrl.sv
// Reaction-timer sequencer: random arm delay, LED stimulus, BCD ms reaction count.
// Latency: outputs registered or decoded from the state register; 1-clk response to inputs.
// No backpressure; optional best-time tracking via `define BEST_TIME_EN.
module reaction_seq_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 2000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    output logic       led,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       done_tick,
    output logic       cheat,
    output logic       timeout,
    output logic       busy
`ifdef BEST_TIME_EN
    ,
    output logic [3:0] best3,
    output logic [3:0] best2,
    output logic [3:0] best1,
    output logic [3:0] best0
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] TIMEOUT_BCD = {4'(TIMEOUT_MS / 1000 % 10), 4'(TIMEOUT_MS / 100 % 10),
                                           4'(TIMEOUT_MS / 10 % 10), 4'(TIMEOUT_MS % 10)};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ARMED,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   delay_q, delay_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          cheat_q, cheat_d;
    logic          timeout_q, timeout_d;
    logic          done_tick_q, done_tick_d;
    logic          start_q;
    logic          start_rise;
    logic          tick;
    logic [15:0]   bcd_inc;
    logic          carry;

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign start_rise = start & ~start_q;
    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Decimal ripple increment across the four digits.
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        bcd_d       = bcd_q;
        cheat_d     = cheat_q;
        timeout_d   = timeout_q;
        done_tick_d = 1'b0;
        if (clr) begin
            state_d   = S_IDLE;
            bcd_d     = 16'h0000;
            cheat_d   = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_rise) begin
                        state_d   = S_WAIT;
                        delay_d   = 16'(MIN_DELAY_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
                        bcd_d     = 16'h0000;
                        cheat_d   = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (stop) begin
                        state_d     = S_DONE;
                        cheat_d     = 1'b1;
                        bcd_d       = 16'h9999;
                        done_tick_d = 1'b1;
                    end else if (tick) begin
                        delay_d = delay_q - 16'd1;
                        if (delay_q == 16'd1) begin
                            state_d = S_ARMED;
                            bcd_d   = 16'h0000;
                        end
                    end
                end
                S_ARMED: begin
                    // A stop wins over a same-cycle tick, so the shown count is never inflated.
                    if (stop) begin
                        state_d     = S_DONE;
                        done_tick_d = 1'b1;
                    end else if (tick) begin
                        bcd_d = bcd_inc;
                        if (bcd_inc == TIMEOUT_BCD) begin
                            state_d     = S_DONE;
                            timeout_d   = 1'b1;
                            done_tick_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Every state change restarts the ms grid so the first tick is a full period away.
    always_comb begin
        if (state_d != state_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            lfsr_q      <= 16'hACE1;
            delay_q     <= 16'd0;
            bcd_q       <= 16'h0000;
            cheat_q     <= 1'b0;
            timeout_q   <= 1'b0;
            done_tick_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lfsr_q      <= lfsr_d;
            delay_q     <= delay_d;
            bcd_q       <= bcd_d;
            cheat_q     <= cheat_d;
            timeout_q   <= timeout_d;
            done_tick_q <= done_tick_d;
            start_q     <= start;
        end
    end

    assign led                    = (state_q == S_ARMED);
    assign busy                   = (state_q == S_WAIT) || (state_q == S_ARMED);
    assign {bcd3, bcd2, bcd1, bcd0} = bcd_q;
    assign done_tick              = done_tick_q;
    assign cheat                  = cheat_q;
    assign timeout                = timeout_q;

`ifdef BEST_TIME_EN
    logic [15:0] best_q, best_d;

    // BCD digits order like binary, so a plain magnitude compare suffices.
    always_comb begin
        best_d = best_q;
        if (!clr && state_q == S_ARMED && stop && bcd_q < best_q) begin
            best_d = bcd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            best_q <= 16'h9999;
        end else begin
            best_q <= best_d;
        end
    end

    assign {best3, best2, best1, best0} = best_q;
`endif

endmodule
